core_mem_arbiter: RTL

//  Shares one memory port between the core's instruction and data request interfaces (val/ack, rdata with ack).

---
 rtl/core_mem_arbiter_pkg.sv | 21 ++
 rtl/core_mem_arb_stats.sv | 42 ++++
 rtl/core_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// Shared encodings for the core memory-port arbiter: FSM states, COP bit positions, fetch codes.
package core_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_I = 2'd1;
    localparam logic [1:0] ARB_GNT_D = 2'd2;

    localparam int unsigned COP_WR = 0;
    localparam int unsigned COP_NC = 1;

    // Instruction fetches are always cached word reads.
    localparam logic [2:0] IFETCH_COP  = 3'b000;
    localparam logic [2:0] IFETCH_SIZE = 3'b100;

    typedef enum logic [1:0] {
        StIdle = ARB_IDLE,
        StGntI = ARB_GNT_I,
        StGntD = ARB_GNT_D
    } arb_state_e;

endpackage

// File: rtl/core_mem_arb_stats.sv
// Wrapping statistics counters for the core memory-port arbiter (present only with
// CORE_MEM_ARB_STATS_EN).
module core_mem_arb_stats #(
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              i_done_i,
    input  logic              d_done_i,
    input  logic              conflict_i,
    output logic [STAT_W-1:0] stat_i_cnt_o,
    output logic [STAT_W-1:0] stat_d_cnt_o,
    output logic [STAT_W-1:0] stat_conf_cnt_o
);

    logic [STAT_W-1:0] i_cnt_q, i_cnt_d;
    logic [STAT_W-1:0] d_cnt_q, d_cnt_d;
    logic [STAT_W-1:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        i_cnt_d    = i_cnt_q + STAT_W'(i_done_i);
        d_cnt_d    = d_cnt_q + STAT_W'(d_done_i);
        conf_cnt_d = conf_cnt_q + STAT_W'(conflict_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign stat_i_cnt_o    = i_cnt_q;
    assign stat_d_cnt_o    = d_cnt_q;
    assign stat_conf_cnt_o = conf_cnt_q;

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction and data requesters; D has priority, a streak
// counter guarantees I progress. Optional statistics under CORE_MEM_ARB_STATS_EN.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned STAT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ack,
    output logic [31:0] i_ack_rdata,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata,
    output logic        m_req_val,
    output logic [31:0] m_req_addr,
    output logic [2:0]  m_req_cop,
    output logic [31:0] m_req_wdata,
    output logic [2:0]  m_req_size,
    input  logic        m_req_ack,
    input  logic [31:0] m_ack_rdata
`ifdef CORE_MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_i_cnt,
    output logic [STAT_W-1:0] stat_d_cnt,
    output logic [STAT_W-1:0] stat_conf_cnt
`endif
);

    localparam int unsigned        StreakW   = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    arb_state_e         state_q, state_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic               sel_i, sel_d;

    always_comb begin
        sel_i   = 1'b0;
        sel_d   = 1'b0;
        state_d = state_q;

        unique case (state_q)
            StIdle: begin
                // D wins unless I has already waited out a full streak.
                if (d_req_val && !(i_req_val && streak_q == StreakMax)) begin
                    sel_d = 1'b1;
                end else if (i_req_val) begin
                    sel_i = 1'b1;
                end
            end
            StGntI:  sel_i = 1'b1;
            StGntD:  sel_d = 1'b1;
            default: ;
        endcase

        m_req_val = !reset && ((sel_i && i_req_val) || (sel_d && d_req_val));

        if (sel_d) begin
            m_req_addr  = d_req_addr;
            m_req_cop   = d_req_cop;
            m_req_wdata = d_req_wdata;
            m_req_size  = d_req_size;
        end else begin
            m_req_addr  = i_req_addr;
            m_req_cop   = IFETCH_COP;
            m_req_wdata = 32'h0;
            m_req_size  = IFETCH_SIZE;
        end

        i_req_ack = m_req_ack && m_req_val && sel_i;
        d_req_ack = m_req_ack && m_req_val && sel_d;

        unique case (state_q)
            StIdle: begin
                if (m_req_val && !m_req_ack) begin
                    state_d = sel_d ? StGntD : StGntI;
                end
            end
            // A dropped val in a locked grant abandons the transaction without an ack.
            StGntI, StGntD: begin
                if (!m_req_val || m_req_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        streak_d = streak_q;
        if (d_req_ack) begin
            if (!i_req_val) begin
                streak_d = '0;
            end else if (streak_q != StreakMax) begin
                streak_d = streak_q + StreakW'(1);
            end
        end else if (i_req_ack) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign i_ack_rdata = m_ack_rdata;
    assign d_ack_rdata = m_ack_rdata;

`ifdef CORE_MEM_ARB_STATS_EN
    core_mem_arb_stats #(
        .STAT_W(STAT_W)
    ) u_stats (
        .clk_i          (clk),
        .reset_i        (reset),
        .i_done_i       (i_req_ack),
        .d_done_i       (d_req_ack),
        .conflict_i     (!reset && state_q == StIdle && i_req_val && d_req_val),
        .stat_i_cnt_o   (stat_i_cnt),
        .stat_d_cnt_o   (stat_d_cnt),
        .stat_conf_cnt_o(stat_conf_cnt)
    );
`endif

endmodule
